// File: rtl/mips_multicycle_ctrl_if.sv
//==============================================================================
// Module   : mips_multicycle_ctrl_if
// Brief    : Bus between the IR/ALU/memory side and the multicycle MIPS controller
// Revision : 1.0
//==============================================================================
`default_nettype none

interface mips_multicycle_ctrl_if #(
    parameter int ST_W = 4
);
    logic [5:0]      opcode;
    logic [5:0]      funct;
    logic            zero;
    logic            mem_ready;
    logic            mem_read;
    logic            mem_write;
    logic            iord;
    logic            ir_write;
    logic            pc_en;
    logic [1:0]      pc_src;
    logic            reg_write;
    logic            reg_dst;
    logic            mem_to_reg;
    logic            alu_src_a;
    logic [1:0]      alu_src_b;
    logic [3:0]      alu_ctrl;
    logic            illegal_op;
    logic [ST_W-1:0] state;

    modport master (
        input  opcode, funct, zero, mem_ready,
        output mem_read, mem_write, iord, ir_write, pc_en, pc_src,
               reg_write, reg_dst, mem_to_reg, alu_src_a, alu_src_b,
               alu_ctrl, illegal_op, state
    );

    modport slave (
        output opcode, funct, zero, mem_ready,
        input  mem_read, mem_write, iord, ir_write, pc_en, pc_src,
               reg_write, reg_dst, mem_to_reg, alu_src_a, alu_src_b,
               alu_ctrl, illegal_op, state
    );
endinterface

`default_nettype wire

// File: rtl/mips_multicycle_ctrl.sv
//==============================================================================
// Module   : mips_multicycle_ctrl
// Brief    : Main control FSM for the multicycle MIPS datapath with a
//            ready/valid memory handshake
// Revision : 1.0
//==============================================================================
`default_nettype none

module mips_multicycle_ctrl #(
    parameter int N    = 32,
    parameter int ST_W = 4
) (
    input  wire logic              clk,
    input  wire logic              rst_n,
    mips_multicycle_ctrl_if.master bus
);

    if (N < 8 || ST_W < 4) begin : g_param_check
        $error("mips_multicycle_ctrl: N must be >= 8 and ST_W >= 4");
    end

    typedef enum logic [ST_W-1:0] {
        S_FETCH  = ST_W'(0),
        S_DECODE = ST_W'(1),
        S_MEMADR = ST_W'(2),
        S_MEMRD  = ST_W'(3),
        S_MEMWB  = ST_W'(4),
        S_MEMWR  = ST_W'(5),
        S_REX    = ST_W'(6),
        S_RWB    = ST_W'(7),
        S_BRANCH = ST_W'(8),
        S_ADDIEX = ST_W'(9),
        S_ADDIWB = ST_W'(10),
        S_JUMP   = ST_W'(11)
    } state_t;

    localparam logic [5:0] c_OP_RTYPE = 6'b000000;
    localparam logic [5:0] c_OP_J     = 6'b000010;
    localparam logic [5:0] c_OP_BEQ   = 6'b000100;
    localparam logic [5:0] c_OP_BNE   = 6'b000101;
    localparam logic [5:0] c_OP_ADDI  = 6'b001000;
    localparam logic [5:0] c_OP_LW    = 6'b100011;
    localparam logic [5:0] c_OP_SW    = 6'b101011;

    localparam logic [5:0] c_FN_ADD = 6'b100000;
    localparam logic [5:0] c_FN_SUB = 6'b100010;
    localparam logic [5:0] c_FN_AND = 6'b100100;
    localparam logic [5:0] c_FN_OR  = 6'b100101;
    localparam logic [5:0] c_FN_SLT = 6'b101010;

    localparam logic [3:0] c_ALU_AND = 4'b0000;
    localparam logic [3:0] c_ALU_OR  = 4'b0001;
    localparam logic [3:0] c_ALU_ADD = 4'b0010;
    localparam logic [3:0] c_ALU_SUB = 4'b0110;
    localparam logic [3:0] c_ALU_SLT = 4'b0111;

    state_t     r_state;
    state_t     w_next_state;
    logic       w_mem_read;
    logic       w_mem_write;
    logic       w_iord;
    logic       w_ir_write;
    logic       w_pc_en;
    logic [1:0] w_pc_src;
    logic       w_reg_write;
    logic       w_reg_dst;
    logic       w_mem_to_reg;
    logic       w_alu_src_a;
    logic [1:0] w_alu_src_b;
    logic [3:0] w_alu_ctrl;
    logic       w_illegal_op;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_FETCH;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Mealy decode: handshake completion and branch outcome act in the same cycle.
    always_comb begin
        w_next_state = r_state;
        w_mem_read   = 1'b0;
        w_mem_write  = 1'b0;
        w_iord       = 1'b0;
        w_ir_write   = 1'b0;
        w_pc_en      = 1'b0;
        w_pc_src     = 2'b00;
        w_reg_write  = 1'b0;
        w_reg_dst    = 1'b0;
        w_mem_to_reg = 1'b0;
        w_alu_src_a  = 1'b0;
        w_alu_src_b  = 2'b00;
        w_alu_ctrl   = c_ALU_ADD;
        w_illegal_op = 1'b0;

        case (r_state)
            S_FETCH: begin
                w_mem_read  = 1'b1;
                w_alu_src_b = 2'b01;
                if (bus.mem_ready) begin
                    w_ir_write   = 1'b1;
                    w_pc_en      = 1'b1;
                    w_next_state = S_DECODE;
                end
            end
            S_DECODE: begin
                w_alu_src_b = 2'b11;
                case (bus.opcode)
                    c_OP_LW, c_OP_SW:   w_next_state = S_MEMADR;
                    c_OP_RTYPE:         w_next_state = S_REX;
                    c_OP_BEQ, c_OP_BNE: w_next_state = S_BRANCH;
                    c_OP_ADDI:          w_next_state = S_ADDIEX;
                    c_OP_J:             w_next_state = S_JUMP;
                    default: begin
                        w_illegal_op = 1'b1;
                        w_next_state = S_FETCH;
                    end
                endcase
            end
            S_MEMADR: begin
                w_alu_src_a  = 1'b1;
                w_alu_src_b  = 2'b10;
                w_next_state = (bus.opcode == c_OP_SW) ? S_MEMWR : S_MEMRD;
            end
            S_MEMRD: begin
                w_mem_read = 1'b1;
                w_iord     = 1'b1;
                if (bus.mem_ready) begin
                    w_next_state = S_MEMWB;
                end
            end
            S_MEMWB: begin
                w_reg_write  = 1'b1;
                w_mem_to_reg = 1'b1;
                w_next_state = S_FETCH;
            end
            S_MEMWR: begin
                w_mem_write = 1'b1;
                w_iord      = 1'b1;
                if (bus.mem_ready) begin
                    w_next_state = S_FETCH;
                end
            end
            S_REX: begin
                w_alu_src_a  = 1'b1;
                w_next_state = S_RWB;
                case (bus.funct)
                    c_FN_ADD: w_alu_ctrl = c_ALU_ADD;
                    c_FN_SUB: w_alu_ctrl = c_ALU_SUB;
                    c_FN_AND: w_alu_ctrl = c_ALU_AND;
                    c_FN_OR:  w_alu_ctrl = c_ALU_OR;
                    c_FN_SLT: w_alu_ctrl = c_ALU_SLT;
                    default: begin
                        w_illegal_op = 1'b1;
                        w_next_state = S_FETCH;
                    end
                endcase
            end
            S_RWB: begin
                w_reg_write  = 1'b1;
                w_reg_dst    = 1'b1;
                w_next_state = S_FETCH;
            end
            S_BRANCH: begin
                w_alu_src_a  = 1'b1;
                w_alu_ctrl   = c_ALU_SUB;
                w_pc_src     = 2'b01;
                w_pc_en      = (bus.opcode == c_OP_BEQ) ? bus.zero : ~bus.zero;
                w_next_state = S_FETCH;
            end
            S_ADDIEX: begin
                w_alu_src_a  = 1'b1;
                w_alu_src_b  = 2'b10;
                w_next_state = S_ADDIWB;
            end
            S_ADDIWB: begin
                w_reg_write  = 1'b1;
                w_next_state = S_FETCH;
            end
            S_JUMP: begin
                w_pc_src     = 2'b10;
                w_pc_en      = 1'b1;
                w_next_state = S_FETCH;
            end
            default: begin
                w_next_state = S_FETCH;
            end
        endcase
    end

    // Reset drops any in-flight memory request immediately, not at the next edge.
    assign bus.mem_read   = rst_n & w_mem_read;
    assign bus.mem_write  = rst_n & w_mem_write;
    assign bus.iord       = rst_n & w_iord;
    assign bus.ir_write   = rst_n & w_ir_write;
    assign bus.pc_en      = rst_n & w_pc_en;
    assign bus.pc_src     = rst_n ? w_pc_src : 2'b00;
    assign bus.reg_write  = rst_n & w_reg_write;
    assign bus.reg_dst    = rst_n & w_reg_dst;
    assign bus.mem_to_reg = rst_n & w_mem_to_reg;
    assign bus.alu_src_a  = rst_n & w_alu_src_a;
    assign bus.alu_src_b  = rst_n ? w_alu_src_b : 2'b00;
    assign bus.alu_ctrl   = rst_n ? w_alu_ctrl : 4'b0000;
    assign bus.illegal_op = rst_n & w_illegal_op;
    assign bus.state      = rst_n ? r_state : S_FETCH;

endmodule

`default_nettype wire

// File: tb/tb_mips_multicycle_ctrl.sv
//==============================================================================
// Module   : tb_mips_multicycle_ctrl
// Brief    : Table-driven check of the multicycle MIPS controller plus CPI runs
// Revision : 1.0
//==============================================================================
`default_nettype none

module tb_mips_multicycle_ctrl;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mips_multicycle_ctrl_if #(.ST_W(4)) bus ();

    mips_multicycle_ctrl #(.N(32), .ST_W(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // {state, mem_read, mem_write, iord, ir_write, pc_en, pc_src, reg_write,
    //  reg_dst, mem_to_reg, alu_src_a, alu_src_b, alu_ctrl, illegal_op}
    typedef struct packed {
        logic [3:0] state;
        logic       mem_read;
        logic       mem_write;
        logic       iord;
        logic       ir_write;
        logic       pc_en;
        logic [1:0] pc_src;
        logic       reg_write;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [3:0] alu_ctrl;
        logic       illegal_op;
    } out_t;

    typedef struct {
        logic       rst_n;
        logic [5:0] opcode;
        logic [5:0] funct;
        logic       zero;
        logic       rdy;
        out_t       exp;
    } vec_t;

    localparam out_t c_RST  = 22'd0;
    localparam out_t c_F    = {4'd0,  1'b1,1'b0,1'b0,1'b0,1'b0, 2'b00, 1'b0,1'b0,1'b0,1'b0, 2'b01, 4'b0010, 1'b0};
    localparam out_t c_FR   = {4'd0,  1'b1,1'b0,1'b0,1'b1,1'b1, 2'b00, 1'b0,1'b0,1'b0,1'b0, 2'b01, 4'b0010, 1'b0};
    localparam out_t c_D    = {4'd1,  1'b0,1'b0,1'b0,1'b0,1'b0, 2'b00, 1'b0,1'b0,1'b0,1'b0, 2'b11, 4'b0010, 1'b0};
    localparam out_t c_DI   = {4'd1,  1'b0,1'b0,1'b0,1'b0,1'b0, 2'b00, 1'b0,1'b0,1'b0,1'b0, 2'b11, 4'b0010, 1'b1};
    localparam out_t c_MA   = {4'd2,  1'b0,1'b0,1'b0,1'b0,1'b0, 2'b00, 1'b0,1'b0,1'b0,1'b1, 2'b10, 4'b0010, 1'b0};
    localparam out_t c_MR   = {4'd3,  1'b1,1'b0,1'b1,1'b0,1'b0, 2'b00, 1'b0,1'b0,1'b0,1'b0, 2'b00, 4'b0010, 1'b0};
    localparam out_t c_WB   = {4'd4,  1'b0,1'b0,1'b0,1'b0,1'b0, 2'b00, 1'b1,1'b0,1'b1,1'b0, 2'b00, 4'b0010, 1'b0};
    localparam out_t c_MW   = {4'd5,  1'b0,1'b1,1'b1,1'b0,1'b0, 2'b00, 1'b0,1'b0,1'b0,1'b0, 2'b00, 4'b0010, 1'b0};
    localparam out_t c_XADD = {4'd6,  1'b0,1'b0,1'b0,1'b0,1'b0, 2'b00, 1'b0,1'b0,1'b0,1'b1, 2'b00, 4'b0010, 1'b0};
    localparam out_t c_XSUB = {4'd6,  1'b0,1'b0,1'b0,1'b0,1'b0, 2'b00, 1'b0,1'b0,1'b0,1'b1, 2'b00, 4'b0110, 1'b0};
    localparam out_t c_XAND = {4'd6,  1'b0,1'b0,1'b0,1'b0,1'b0, 2'b00, 1'b0,1'b0,1'b0,1'b1, 2'b00, 4'b0000, 1'b0};
    localparam out_t c_XOR  = {4'd6,  1'b0,1'b0,1'b0,1'b0,1'b0, 2'b00, 1'b0,1'b0,1'b0,1'b1, 2'b00, 4'b0001, 1'b0};
    localparam out_t c_XSLT = {4'd6,  1'b0,1'b0,1'b0,1'b0,1'b0, 2'b00, 1'b0,1'b0,1'b0,1'b1, 2'b00, 4'b0111, 1'b0};
    localparam out_t c_XILL = {4'd6,  1'b0,1'b0,1'b0,1'b0,1'b0, 2'b00, 1'b0,1'b0,1'b0,1'b1, 2'b00, 4'b0010, 1'b1};
    localparam out_t c_RWB  = {4'd7,  1'b0,1'b0,1'b0,1'b0,1'b0, 2'b00, 1'b1,1'b1,1'b0,1'b0, 2'b00, 4'b0010, 1'b0};
    localparam out_t c_BT   = {4'd8,  1'b0,1'b0,1'b0,1'b0,1'b1, 2'b01, 1'b0,1'b0,1'b0,1'b1, 2'b00, 4'b0110, 1'b0};
    localparam out_t c_BN   = {4'd8,  1'b0,1'b0,1'b0,1'b0,1'b0, 2'b01, 1'b0,1'b0,1'b0,1'b1, 2'b00, 4'b0110, 1'b0};
    localparam out_t c_AEX  = {4'd9,  1'b0,1'b0,1'b0,1'b0,1'b0, 2'b00, 1'b0,1'b0,1'b0,1'b1, 2'b10, 4'b0010, 1'b0};
    localparam out_t c_AWB  = {4'd10, 1'b0,1'b0,1'b0,1'b0,1'b0, 2'b00, 1'b1,1'b0,1'b0,1'b0, 2'b00, 4'b0010, 1'b0};
    localparam out_t c_J    = {4'd11, 1'b0,1'b0,1'b0,1'b0,1'b1, 2'b10, 1'b0,1'b0,1'b0,1'b0, 2'b00, 4'b0010, 1'b0};

    localparam logic [5:0] c_LW = 6'b100011, c_SW = 6'b101011, c_R = 6'b000000;
    localparam logic [5:0] c_BEQ = 6'b000100, c_BNE = 6'b000101, c_ADDI = 6'b001000;
    localparam logic [5:0] c_JMP = 6'b000010, c_BAD = 6'b111111;

    vec_t vecs[$];
    int   n_vec = 0;
    int   n_err = 0;

    function automatic out_t sample_out();
        return {bus.state, bus.mem_read, bus.mem_write, bus.iord, bus.ir_write,
                bus.pc_en, bus.pc_src, bus.reg_write, bus.reg_dst, bus.mem_to_reg,
                bus.alu_src_a, bus.alu_src_b, bus.alu_ctrl, bus.illegal_op};
    endfunction

    task automatic add(input logic r, input logic [5:0] op, input logic [5:0] fn,
                       input logic z, input logic rdy, input out_t e);
        vec_t v;
        v.rst_n = r; v.opcode = op; v.funct = fn; v.zero = z; v.rdy = rdy; v.exp = e;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input int idx, input out_t got, input out_t exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s[%0d]: got %h expected %h (state got %0d exp %0d)",
                     name, idx, got, exp, got.state, exp.state);
        end
    endtask

    // Counts rising edges from FETCH until the controller is back in FETCH.
    task automatic run_cpi(input string name, input logic [5:0] op, input int exp_cycles);
        int  cycles;
        bit  done;
        cycles = 0;
        done   = 1'b0;
        bus.opcode    = op;
        bus.funct     = 6'b100000;
        bus.zero      = 1'b1;
        bus.mem_ready = 1'b1;
        for (int k = 0; k < 20 && !done; k++) begin
            @(posedge clk);
            #1;
            cycles++;
            if (bus.state == 4'd0) done = 1'b1;
        end
        n_vec++;
        if (!done || cycles != exp_cycles) begin
            n_err++;
            $display("FAIL cpi_%s: got %0d cycles (returned=%0d) expected %0d",
                     name, cycles, done, exp_cycles);
        end
    endtask

    initial begin
        bus.opcode = 6'd0; bus.funct = 6'd0; bus.zero = 1'b0; bus.mem_ready = 1'b0;

        add(0, c_LW,   6'd0,      0, 1, c_RST);
        // lw with memory always ready
        add(1, c_LW,   6'd0,      0, 1, c_FR);
        add(1, c_LW,   6'd0,      0, 1, c_D);
        add(1, c_LW,   6'd0,      0, 1, c_MA);
        add(1, c_LW,   6'd0,      0, 1, c_MR);
        add(1, c_LW,   6'd0,      0, 1, c_WB);
        // sw with a 3-cycle fetch stall and a 1-cycle write stall
        add(1, c_SW,   6'd0,      0, 0, c_F);
        add(1, c_SW,   6'd0,      0, 0, c_F);
        add(1, c_SW,   6'd0,      0, 0, c_F);
        add(1, c_SW,   6'd0,      0, 1, c_FR);
        add(1, c_SW,   6'd0,      0, 1, c_D);
        add(1, c_SW,   6'd0,      0, 1, c_MA);
        add(1, c_SW,   6'd0,      0, 0, c_MW);
        add(1, c_SW,   6'd0,      0, 1, c_MW);
        // R-type: sub, bad funct, and, slt, or, add
        add(1, c_R,    6'b100010, 0, 1, c_FR);
        add(1, c_R,    6'b100010, 0, 1, c_D);
        add(1, c_R,    6'b100010, 0, 1, c_XSUB);
        add(1, c_R,    6'b100010, 0, 1, c_RWB);
        add(1, c_R,    6'b000111, 0, 1, c_FR);
        add(1, c_R,    6'b000111, 0, 1, c_D);
        add(1, c_R,    6'b000111, 0, 1, c_XILL);
        add(1, c_R,    6'b100100, 0, 1, c_FR);
        add(1, c_R,    6'b100100, 0, 1, c_D);
        add(1, c_R,    6'b100100, 0, 1, c_XAND);
        add(1, c_R,    6'b100100, 0, 1, c_RWB);
        add(1, c_R,    6'b101010, 0, 1, c_FR);
        add(1, c_R,    6'b101010, 0, 1, c_D);
        add(1, c_R,    6'b101010, 0, 1, c_XSLT);
        add(1, c_R,    6'b101010, 0, 1, c_RWB);
        add(1, c_R,    6'b100101, 0, 1, c_FR);
        add(1, c_R,    6'b100101, 0, 1, c_D);
        add(1, c_R,    6'b100101, 0, 1, c_XOR);
        add(1, c_R,    6'b100101, 0, 1, c_RWB);
        add(1, c_R,    6'b100000, 0, 1, c_FR);
        add(1, c_R,    6'b100000, 0, 1, c_D);
        add(1, c_R,    6'b100000, 0, 1, c_XADD);
        add(1, c_R,    6'b100000, 0, 1, c_RWB);
        // branches: beq taken/not taken, bne taken/not taken
        add(1, c_BEQ,  6'd0,      1, 1, c_FR);
        add(1, c_BEQ,  6'd0,      1, 1, c_D);
        add(1, c_BEQ,  6'd0,      1, 1, c_BT);
        add(1, c_BEQ,  6'd0,      0, 1, c_FR);
        add(1, c_BEQ,  6'd0,      0, 1, c_D);
        add(1, c_BEQ,  6'd0,      0, 1, c_BN);
        add(1, c_BNE,  6'd0,      0, 1, c_FR);
        add(1, c_BNE,  6'd0,      0, 1, c_D);
        add(1, c_BNE,  6'd0,      0, 1, c_BT);
        add(1, c_BNE,  6'd0,      1, 1, c_FR);
        add(1, c_BNE,  6'd0,      1, 1, c_D);
        add(1, c_BNE,  6'd0,      1, 1, c_BN);
        // addi, j, illegal opcode
        add(1, c_ADDI, 6'd0,      0, 1, c_FR);
        add(1, c_ADDI, 6'd0,      0, 1, c_D);
        add(1, c_ADDI, 6'd0,      0, 1, c_AEX);
        add(1, c_ADDI, 6'd0,      0, 1, c_AWB);
        add(1, c_JMP,  6'd0,      0, 1, c_FR);
        add(1, c_JMP,  6'd0,      0, 1, c_D);
        add(1, c_JMP,  6'd0,      0, 1, c_J);
        add(1, c_BAD,  6'd0,      0, 1, c_FR);
        add(1, c_BAD,  6'd0,      0, 1, c_DI);
        // reset in the middle of a stalled MEMRD handshake
        add(1, c_LW,   6'd0,      0, 1, c_FR);
        add(1, c_LW,   6'd0,      0, 1, c_D);
        add(1, c_LW,   6'd0,      0, 1, c_MA);
        add(1, c_LW,   6'd0,      0, 0, c_MR);
        add(0, c_LW,   6'd0,      0, 0, c_RST);
        add(1, c_LW,   6'd0,      0, 0, c_F);
        add(1, c_LW,   6'd0,      0, 1, c_FR);
        add(1, c_LW,   6'd0,      0, 1, c_D);

        foreach (vecs[i]) begin
            @(negedge clk);
            rst_n         = vecs[i].rst_n;
            bus.opcode    = vecs[i].opcode;
            bus.funct     = vecs[i].funct;
            bus.zero      = vecs[i].zero;
            bus.mem_ready = vecs[i].rdy;
            #1;
            check("vec", i, sample_out(), vecs[i].exp);
        end

        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("post_reset", 0, sample_out(), c_RST | c_FR);

        run_cpi("j",   c_JMP, 3);
        run_cpi("lw",  c_LW,  5);
        run_cpi("sw",  c_SW,  4);
        run_cpi("beq", c_BEQ, 3);
        run_cpi("addi", c_ADDI, 4);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1);
    end

endmodule

`default_nettype wire
